rob_retire_2way: RTL and testbench

//  2-way reorder buffer: takes up to 2 renamed instrs/cycle from dispatch, marks them done from
//  the CDB, retires up to 2/cycle in program order. Drives the retire bus (new tag, old tag,

---
 rtl/rob_retire_2way.sv | 188 ++++++++++++++++++
 tb/tb_rob_retire_2way.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire_2way.sv
// 2-way reorder buffer: dispatch up to 2/cycle, completion from two CDB lanes, in-order retire up to 2/cycle.
// Optional feature macro: ROB_BRANCH_FLUSH_EN (retire a mispredicted head alone and flush the buffer).
module rob_retire_2way #(
   parameter int  ROB_SIZE  = 32,
   parameter int  PHYS_BITS = 6,
   localparam int IDX_BITS  = $clog2(ROB_SIZE)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [1:0]               id_nDispatch,
   input  logic [2*PHYS_BITS-1:0]   id_destTag,
   input  logic [2*PHYS_BITS-1:0]   id_destTagOld,
   input  logic [1:0]               cdb_valid,
   input  logic [2*IDX_BITS-1:0]    cdb_robIdx,
   input  logic [1:0]               cdb_mispredict,
   output logic [2*IDX_BITS-1:0]    rob_tailIdx,
   output logic [1:0]               rob_availSlots,
   output logic [2*PHYS_BITS-1:0]   rob_retireTag,
   output logic [2*PHYS_BITS-1:0]   rob_retireTagOld,
   output logic [1:0]               rob_nRetired,
   output logic                     rob_flush
);

   localparam int CNT_W = IDX_BITS + 1;

   // Dispatch handshake: upstream may offer any id_nDispatch; only min(offer, rob_availSlots)
   // instructions are written, the rest are dropped, so upstream must stall on rob_availSlots.

   logic [IDX_BITS-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 valid_q [ROB_SIZE];
   logic                 valid_d [ROB_SIZE];
   logic                 done_q  [ROB_SIZE];
   logic                 done_d  [ROB_SIZE];
   logic [PHYS_BITS-1:0] tag_q     [ROB_SIZE];
   logic [PHYS_BITS-1:0] tag_d     [ROB_SIZE];
   logic [PHYS_BITS-1:0] tag_old_q [ROB_SIZE];
   logic [PHYS_BITS-1:0] tag_old_d [ROB_SIZE];
`ifdef ROB_BRANCH_FLUSH_EN
   logic                 mispred_q [ROB_SIZE];
   logic                 mispred_d [ROB_SIZE];
`else
   logic                 unused_mispredict;
   assign unused_mispredict = ^cdb_mispredict;
`endif

   logic [IDX_BITS-1:0]  head_p1, tail_p1, cidx0, cidx1;
   logic [1:0]           avail, n_req, accepted, n_ret;
   logic                 r0, r1, flush;

   assign head_p1 = head_q + IDX_BITS'(1);
   assign tail_p1 = tail_q + IDX_BITS'(1);
   assign cidx0   = cdb_robIdx[IDX_BITS-1:0];
   assign cidx1   = cdb_robIdx[2*IDX_BITS-1:IDX_BITS];

   always_comb begin
      avail = 2'd2;
      if (count_q == CNT_W'(ROB_SIZE))
         avail = 2'd0;
      else if (count_q == CNT_W'(ROB_SIZE - 1))
         avail = 2'd1;
      n_req    = (id_nDispatch > 2'd2) ? 2'd2 : id_nDispatch;
      accepted = (n_req < avail) ? n_req : avail;

      r0    = valid_q[head_q] & done_q[head_q];
      r1    = r0 & valid_q[head_p1] & done_q[head_p1];
      flush = 1'b0;
`ifdef ROB_BRANCH_FLUSH_EN
      // A mispredicted head retires alone; anything younger is wrong-path.
      if (r0 && mispred_q[head_q]) begin
         r1    = 1'b0;
         flush = 1'b1;
      end
`endif
      n_ret = {1'b0, r0} + {1'b0, r1};
   end

   always_comb begin
      valid_d   = valid_q;
      done_d    = done_q;
      tag_d     = tag_q;
      tag_old_d = tag_old_q;
`ifdef ROB_BRANCH_FLUSH_EN
      mispred_d = mispred_q;
`endif
      head_d  = head_q + IDX_BITS'(n_ret);
      tail_d  = tail_q + IDX_BITS'(accepted);
      count_d = count_q + CNT_W'(accepted) - CNT_W'(n_ret);

      if (cdb_valid[0] && valid_q[cidx0]) begin
         done_d[cidx0] = 1'b1;
`ifdef ROB_BRANCH_FLUSH_EN
         mispred_d[cidx0] = cdb_mispredict[0];
`endif
      end
      if (cdb_valid[1] && valid_q[cidx1]) begin
         done_d[cidx1] = 1'b1;
`ifdef ROB_BRANCH_FLUSH_EN
         mispred_d[cidx1] = cdb_mispredict[1] |
                            (cdb_valid[0] && (cidx0 == cidx1) && cdb_mispredict[0]);
`endif
      end

      if (r0) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
`ifdef ROB_BRANCH_FLUSH_EN
         mispred_d[head_q] = 1'b0;
`endif
      end
      if (r1) begin
         valid_d[head_p1] = 1'b0;
         done_d[head_p1]  = 1'b0;
`ifdef ROB_BRANCH_FLUSH_EN
         mispred_d[head_p1] = 1'b0;
`endif
      end

      // Dispatch targets are free entries, so they never collide with completes or retires.
      if (accepted != 2'd0) begin
         valid_d[tail_q]   = 1'b1;
         done_d[tail_q]    = 1'b0;
         tag_d[tail_q]     = id_destTag[PHYS_BITS-1:0];
         tag_old_d[tail_q] = id_destTagOld[PHYS_BITS-1:0];
`ifdef ROB_BRANCH_FLUSH_EN
         mispred_d[tail_q] = 1'b0;
`endif
      end
      if (accepted == 2'd2) begin
         valid_d[tail_p1]   = 1'b1;
         done_d[tail_p1]    = 1'b0;
         tag_d[tail_p1]     = id_destTag[2*PHYS_BITS-1:PHYS_BITS];
         tag_old_d[tail_p1] = id_destTagOld[2*PHYS_BITS-1:PHYS_BITS];
`ifdef ROB_BRANCH_FLUSH_EN
         mispred_d[tail_p1] = 1'b0;
`endif
      end

      if (flush) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            valid_d[i] = 1'b0;
            done_d[i]  = 1'b0;
`ifdef ROB_BRANCH_FLUSH_EN
            mispred_d[i] = 1'b0;
`endif
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < ROB_SIZE; i++) begin
            valid_q[i]   <= 1'b0;
            done_q[i]    <= 1'b0;
            tag_q[i]     <= '0;
            tag_old_q[i] <= '0;
`ifdef ROB_BRANCH_FLUSH_EN
            mispred_q[i] <= 1'b0;
`endif
         end
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         done_q    <= done_d;
         tag_q     <= tag_d;
         tag_old_q <= tag_old_d;
`ifdef ROB_BRANCH_FLUSH_EN
         mispred_q <= mispred_d;
`endif
      end
   end

   assign rob_tailIdx      = {tail_p1, tail_q};
   assign rob_availSlots   = avail;
   assign rob_nRetired     = n_ret;
   assign rob_flush        = flush;
   assign rob_retireTag    = {r1 ? tag_q[head_p1] : '0, r0 ? tag_q[head_q] : '0};
   assign rob_retireTagOld = {r1 ? tag_old_q[head_p1] : '0, r0 ? tag_old_q[head_q] : '0};

endmodule

// File: tb/tb_rob_retire_2way.sv
// Directed bench for rob_retire_2way: expected retire records queue up at stimulus time and a
// negedge monitor pops one whenever the DUT reports a retire.
module tb_rob_retire_2way;

   logic        clk;
   logic        reset;
   logic [1:0]  id_nDispatch;
   logic [11:0] id_destTag, id_destTagOld;
   logic [1:0]  cdb_valid;
   logic [9:0]  cdb_robIdx;
   logic [1:0]  cdb_mispredict;
   logic [9:0]  rob_tailIdx;
   logic [1:0]  rob_availSlots;
   logic [11:0] rob_retireTag, rob_retireTagOld;
   logic [1:0]  rob_nRetired;
   logic        rob_flush;

   int total = 0;
   int bad   = 0;

   // record = {n, tag1, tag0, old1, old0, flush}
   logic [26:0] exp_q[$];

   rob_retire_2way dut (
      .clk(clk), .reset(reset),
      .id_nDispatch(id_nDispatch), .id_destTag(id_destTag), .id_destTagOld(id_destTagOld),
      .cdb_valid(cdb_valid), .cdb_robIdx(cdb_robIdx), .cdb_mispredict(cdb_mispredict),
      .rob_tailIdx(rob_tailIdx), .rob_availSlots(rob_availSlots),
      .rob_retireTag(rob_retireTag), .rob_retireTagOld(rob_retireTagOld),
      .rob_nRetired(rob_nRetired), .rob_flush(rob_flush)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [26:0] rec(input logic [1:0] n, input logic [5:0] t1, input logic [5:0] t0,
                                       input logic [5:0] o1, input logic [5:0] o0, input logic f);
      return {n, t1, t0, o1, o0, f};
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin
      if (!reset && rob_nRetired != 2'd0) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_retire actual n=%0d tag=%0h old=%0h", rob_nRetired,
                     rob_retireTag, rob_retireTagOld);
         end else begin
            check("retire_record", {rob_nRetired, rob_retireTag, rob_retireTagOld, rob_flush},
                  exp_q.pop_front());
         end
      end else if (!reset && rob_flush) begin
         check("flush_without_retire", rob_flush, 1'b0);
      end
   end

   // drivers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_nDispatch   = 2'd0;
      cdb_valid      = 2'b00;
      cdb_mispredict = 2'b00;
   endtask

   task automatic dispatch(input logic [1:0] n, input logic [5:0] t0, input logic [5:0] o0,
                           input logic [5:0] t1, input logic [5:0] o1);
      id_nDispatch  = n;
      id_destTag    = {t1, t0};
      id_destTagOld = {o1, o0};
      step();
      idle();
   endtask

   task automatic complete(input logic [1:0] v, input logic [4:0] i0, input logic [4:0] i1,
                           input logic [1:0] m);
      cdb_valid      = v;
      cdb_robIdx     = {i1, i0};
      cdb_mispredict = m;
      step();
      idle();
   endtask

   initial begin
      reset         = 1'b1;
      idle();
      id_destTag    = '0;
      id_destTagOld = '0;
      cdb_robIdx    = '0;
      #2;
      check("reset_nret", rob_nRetired, 2'd0);
      check("reset_avail", rob_availSlots, 2'd2);
      check("reset_tailidx", rob_tailIdx, {5'd1, 5'd0});
      check("reset_flush", rob_flush, 1'b0);
      check("reset_tags", {rob_retireTag, rob_retireTagOld}, 24'd0);
      step();
      reset = 1'b0;
      step();

      // pair retires only once the older entry completes
      dispatch(2'd2, 6'd33, 6'd1, 6'd34, 6'd2);
      check("t2_tailidx", rob_tailIdx, {5'd3, 5'd2});
      check("t2_avail", rob_availSlots, 2'd2);
      complete(2'b01, 5'd1, 5'd0, 2'b00);
      check("t2_no_retire_young_done", rob_nRetired, 2'd0);
      exp_q.push_back(rec(2'd2, 6'd34, 6'd33, 6'd2, 6'd1, 1'b0));
      complete(2'b01, 5'd0, 5'd0, 2'b00);
      step();

      // head done, head+1 not
      dispatch(2'd2, 6'd10, 6'd20, 6'd11, 6'd21);
      exp_q.push_back(rec(2'd1, 6'd0, 6'd10, 6'd0, 6'd20, 1'b0));
      complete(2'b01, 5'd2, 5'd0, 2'b00);
      step();
      check("t4_wait_head1", rob_nRetired, 2'd0);
      exp_q.push_back(rec(2'd1, 6'd0, 6'd11, 6'd0, 6'd21, 1'b0));
      complete(2'b01, 5'd3, 5'd0, 2'b00);
      step();

      // reset with 5 valid entries at idx 4..8
      dispatch(2'd2, 6'd5, 6'd6, 6'd7, 6'd8);
      dispatch(2'd2, 6'd9, 6'd10, 6'd11, 6'd12);
      dispatch(2'd1, 6'd13, 6'd14, 6'd0, 6'd0);
      check("t1_tailidx_before", rob_tailIdx, {5'd10, 5'd9});
      reset = 1'b1;
      #1;
      check("t1_async_tailidx", rob_tailIdx, {5'd1, 5'd0});
      step();
      reset = 1'b0;
      step();
      check("t1_nret", rob_nRetired, 2'd0);
      check("t1_avail", rob_availSlots, 2'd2);
      check("t1_tailidx", rob_tailIdx, {5'd1, 5'd0});
      complete(2'b11, 5'd0, 5'd4, 2'b00);
      check("t1_stale_complete_ignored", rob_nRetired, 2'd0);

      // fill to 32, then an extra dispatch is dropped
      for (int k = 0; k < 16; k++) begin
         check("t3_avail_fill", rob_availSlots, 2'd2);
         dispatch(2'd2, 6'(2*k), 6'(2*k+32), 6'(2*k+1), 6'(2*k+33));
      end
      check("t3_full_avail", rob_availSlots, 2'd0);
      check("t3_full_tailidx", rob_tailIdx, {5'd1, 5'd0});
      dispatch(2'd2, 6'd60, 6'd61, 6'd62, 6'd63);
      check("t3_drop_tailidx", rob_tailIdx, {5'd1, 5'd0});
      check("t3_drop_avail", rob_availSlots, 2'd0);

      // drain entries 0..29 two per cycle
      for (int j = 0; j < 15; j++)
         exp_q.push_back(rec(2'd2, 6'(2*j+1), 6'(2*j), 6'(2*j+33), 6'(2*j+32), 1'b0));
      for (int j = 0; j < 15; j++) begin
         complete(2'b11, 5'(2*j), 5'(2*j+1), 2'b00);
         if (j == 0) check("t3_full_retiring_avail", rob_availSlots, 2'd0);
      end
      step();

      // pair straddling the wrap: entries 31 and 0
      exp_q.push_back(rec(2'd1, 6'd0, 6'd30, 6'd0, 6'd62, 1'b0));
      complete(2'b01, 5'd30, 5'd0, 2'b00);
      step();
      check("t5_tailidx", rob_tailIdx, {5'd1, 5'd0});
      dispatch(2'd1, 6'd50, 6'd51, 6'd0, 6'd0);
      exp_q.push_back(rec(2'd2, 6'd50, 6'd31, 6'd51, 6'd63, 1'b0));
      complete(2'b11, 5'd31, 5'd0, 2'b00);
      step();
      check("t5_tailidx_after", rob_tailIdx, {5'd2, 5'd1});
      check("t5_avail_after", rob_availSlots, 2'd2);

      // mispredicted head with younger done entry and a same-cycle dispatch
      dispatch(2'd2, 6'd40, 6'd41, 6'd42, 6'd43);
`ifdef ROB_BRANCH_FLUSH_EN
      exp_q.push_back(rec(2'd1, 6'd0, 6'd40, 6'd0, 6'd41, 1'b1));
`else
      exp_q.push_back(rec(2'd2, 6'd42, 6'd40, 6'd43, 6'd41, 1'b0));
`endif
      complete(2'b11, 5'd1, 5'd2, 2'b01);
      dispatch(2'd2, 6'd44, 6'd45, 6'd46, 6'd47);
      check("t6_nret_after", rob_nRetired, 2'd0);
      check("t6_avail_after", rob_availSlots, 2'd2);
`ifdef ROB_BRANCH_FLUSH_EN
      check("t6_tailidx_after", rob_tailIdx, {5'd1, 5'd0});
`else
      check("t6_tailidx_after", rob_tailIdx, {5'd6, 5'd5});
`endif

      step();
      step();
      check("scoreboard_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
